alu_result_fifo: RTL and testbench

Result buffer directly downstream of the 3-stage pipelined ALU. It captures every non-NOP result (res, databits, op) the ALU emits and presents the results to a consumer over a valid/ready handshake in first-word-fall-through order. The ALU cannot stall, so this block also returns an issue_ok credit to the upstream issuer, with margin for results already in the pipeline. It flags any result lost to overflow.

---
 rtl/alu_result_fifo.sv | 128 ++++++++++++
 tb/tb_alu_result_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through buffer for non-NOP results of the 3-stage ALU.
// Latency: a result written in cycle N is visible on out_* in cycle N+1.
// Backpressure: the ALU cannot stall. issue_ok throttles the issuer with SKID entries of margin. A write into a full FIFO with no read is dropped and counted.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   in_res/in_databits/in_op: ALU result stream; in_op == OP_NOP marks an empty slot
//   out_valid/out_ready    : consumer handshake; out_res/out_databits/out_op carry the head entry
//   count                  : occupancy 0..DEPTH
//   issue_ok               : upstream may issue a new ALU op
//   overflow/drop_count    : sticky loss flag and saturating count of dropped results
module alu_result_fifo #(
    parameter int         WIDTH     = 32,
    parameter int         DATABITS  = 7,
    parameter int         DEPTH     = 8,
    parameter int         ADDR_BITS = 3,
    parameter logic [1:0] OP_NOP    = 2'd0,
    parameter int         SKID      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_res,
    input  logic [DATABITS-1:0]  in_databits,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_res,
    output logic [DATABITS-1:0]  out_databits,
    output logic [1:0]           out_op,
    output logic [ADDR_BITS:0]   count,
    output logic                 issue_ok,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    typedef struct packed {
        logic [1:0]          op;
        logic [DATABITS-1:0] databits;
        logic [WIDTH-1:0]    res;
    } entry_t;

    localparam logic [ADDR_BITS:0] DEPTH_C = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] SKID_C  = SKID[ADDR_BITS:0];

    entry_t                 mem_q [DEPTH];
    entry_t                 mem_d [DEPTH];
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_count_q, drop_count_d;

    logic                   wr_evt;
    logic                   rd_evt;
    logic                   full;
    logic                   wr_acc;
    logic                   wr_drop;
    logic [ADDR_BITS:0]     free_slots;
    entry_t                 head;

    always_comb begin
        wr_evt  = (in_op != OP_NOP);
        rd_evt  = out_valid && out_ready;
        full    = (count_q == DEPTH_C);
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr_acc  = wr_evt && (!full || rd_evt);
        wr_drop = wr_evt && full && !rd_evt;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = '{op: in_op, databits: in_databits, res: in_res};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_evt) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (wr_acc && !rd_evt) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && rd_evt) begin
            count_d = count_q - 1'b1;
        end

        overflow_d   = overflow_q || wr_drop;
        drop_count_d = drop_count_q;
        if (wr_drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Outputs come only from registered state; the head is forced to zero when empty.
    always_comb begin
        out_valid    = (count_q != '0);
        head         = mem_q[rd_ptr_q];
        out_res      = out_valid ? head.res      : '0;
        out_databits = out_valid ? head.databits : '0;
        out_op       = out_valid ? head.op       : 2'd0;
        count        = count_q;
        free_slots   = DEPTH_C - count_q;
        issue_ok     = (free_slots > SKID_C);
        overflow     = overflow_q;
        drop_count   = drop_count_q;
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed bench for alu_result_fifo with hand-computed expectations.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked there too.
// Backpressure: out_ready is driven explicitly per phase.
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_res;
    logic [6:0]  in_databits;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [6:0]  out_databits;
    logic [1:0]  out_op;
    logic [3:0]  count;
    logic        issue_ok;
    logic        overflow;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .in_res       (in_res),
        .in_databits  (in_databits),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_databits (out_databits),
        .out_op       (out_op),
        .count        (count),
        .issue_ok     (issue_ok),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] res, input logic [6:0] db);
        in_op       = op;
        in_res      = res;
        in_databits = db;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int          c;

        reset     = 1'b1;
        out_ready = 1'b0;
        drive(2'd0, 32'd0, 7'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_count",    32'(count), 32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_res",      out_res, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drops",    32'(drop_count), 32'd0);
        check("rst_issue_ok", 32'(issue_ok), 32'd1);

        // Three writes, then drain in order
        for (int i = 0; i < 3; i++) begin
            drive(2'd1, 32'h11 * (i + 1), 7'(i + 1));
            tick();
        end
        drive(2'd0, 32'd0, 7'd0);
        check("w3_count", 32'(count), 32'd3);
        check("w3_valid", 32'(out_valid), 32'd1);
        check("w3_head",  out_res, 32'h11);
        tick();
        check("w3_hold",  out_res, 32'h11);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("w3_res", out_res, 32'h11 * (i + 1));
            check("w3_db",  32'(out_databits), 32'(i + 1));
            check("w3_op",  32'(out_op), 32'd1);
            tick();
        end
        check("w3_empty_count", 32'(count), 32'd0);
        check("w3_empty_valid", 32'(out_valid), 32'd0);
        check("w3_empty_res",   out_res, 32'd0);
        check("w3_empty_db",    32'(out_databits), 32'd0);
        check("w3_empty_op",    32'(out_op), 32'd0);

        // NOP cycles with junk data are never stored
        for (int i = 0; i < 10; i++) begin
            drive(2'd0, 32'hA5A5_0000 + 32'(i), 7'(i));
            tick();
            check("nop_count", 32'(count), 32'd0);
        end
        check("nop_valid", 32'(out_valid), 32'd0);

        // Fill to 8, then overflow by 2
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(2'd1, 32'h100 + 32'(i), 7'(i));
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_issue_ok", 32'(issue_ok), ((8 - (i + 1)) > 4) ? 32'd1 : 32'd0);
        end
        check("fill_overflow_pre", 32'(overflow), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(2'd2, 32'hDEAD0 + 32'(i), 7'h7F);
            tick();
        end
        drive(2'd0, 32'd0, 7'd0);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_head",  out_res, 32'h100);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_res", out_res, 32'h100 + 32'(i));
            check("ovf_drain_db",  32'(out_databits), 32'(i));
            tick();
        end
        check("ovf_drain_count", 32'(count), 32'd0);

        // Full with simultaneous read+write for 20 cycles; pointers wrap
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(2'd1, 32'h200 + 32'(i), 7'(i));
            exp_q.push_back(32'h200 + 32'(i));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(2'd1, 32'h300 + 32'(k), 7'(k));
            check("rw_head", out_res, exp_q[0]);
            exp_q.pop_front();
            exp_q.push_back(32'h300 + 32'(k));
            tick();
            check("rw_count", 32'(count), 32'd8);
        end
        drive(2'd0, 32'd0, 7'd0);
        check("rw_drops", 32'(drop_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("rw_drain", out_res, exp_q[0]);
            exp_q.pop_front();
            tick();
        end
        check("rw_empty", 32'(out_valid), 32'd0);

        // Single MULT entry into empty FIFO: visible one cycle later
        out_ready = 1'b0;
        drive(2'd3, 32'hCAFE_F00D, 7'h55);
        check("single_pre_valid", 32'(out_valid), 32'd0);
        tick();
        drive(2'd0, 32'd0, 7'd0);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_res",   out_res, 32'hCAFE_F00D);
        check("single_db",    32'(out_databits), 32'h55);
        check("single_op",    32'(out_op), 32'd3);
        out_ready = 1'b1;
        tick();
        check("single_gone", 32'(count), 32'd0);

        // Drop counter saturates at 255
        out_ready = 1'b0;
        c = 0;
        for (int i = 0; i < 8 + 260; i++) begin
            drive(2'd1, 32'h400 + 32'(i), 7'd1);
            tick();
        end
        drive(2'd0, 32'd0, 7'd0);
        check("sat_drops", 32'(drop_count), 32'd255);
        check("sat_head",  out_res, 32'h400);

        // Bring count to 5, then reset alongside a write
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            c++;
        end
        out_ready = 1'b0;
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_ovf",   32'(overflow), 32'd1);
        check("pre_rst_ok",    32'(issue_ok), 32'd0);
        reset = 1'b1;
        drive(2'd1, 32'h999, 7'h9);
        tick();
        reset = 1'b0;
        drive(2'd0, 32'd0, 7'd0);
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_ovf",   32'(overflow), 32'd0);
        check("rst2_drops", 32'(drop_count), 32'd0);
        check("rst2_ok",    32'(issue_ok), 32'd1);
        check("rst2_res",   out_res, 32'd0);
        tick();
        check("rst2_not_stored", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
